// File: rtl/seq_detect_ctrl.sv
// Programmable serial sequence detector: loads a pattern of 1..MAX_LEN bits,
// scans a qualified bit stream, flags matches Mealy-style and stops at a target count.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               abort,
    input  logic               in_valid,
    input  logic               in,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]   LP_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LP_LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LP_LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [CNT_W-1:0]   LP_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   LP_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MAX_LEN-1:0] LP_PAT_ZERO = {MAX_LEN{1'b0}};

    // A length of zero or beyond the shift register cannot describe a pattern.
    function automatic logic len_illegal(input logic [LEN_W-1:0] len);
        return (len == LP_LEN_ZERO) || (len > LP_MAX_LEN);
    endfunction

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < MAX_LEN; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LP_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [CNT_W-1:0]   r_target;
    logic               r_cfg_err;
    logic [MAX_LEN-1:0] r_shreg;
    logic [LEN_W-1:0]   r_fill;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;

    logic [MAX_LEN-1:0] w_shreg_next;
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_scan_bit;
    logic               w_start_ok;
    logic               w_match;
    logic               w_final;
    logic               w_busy_next;
    logic               w_done_next;

    // State register with registered busy/done decodes of the next state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; abort dominates, start needs the currently stored config to be legal.
    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start && !r_cfg_err) begin
                        w_state_next = ST_SCAN;
                    end else begin
                        w_state_next = r_state;
                    end
                end
                ST_SCAN: begin
                    if (w_match && w_final) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_SCAN;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output and scan-datapath decode, including the Mealy match flag.
    always_comb begin
        w_scan_bit   = (r_state == ST_SCAN) && in_valid && !abort;
        w_start_ok   = (r_state != ST_SCAN) && start && !r_cfg_err && !abort;
        w_shreg_next = {r_shreg[MAX_LEN-2:0], in};
        w_mask       = len_mask(r_len);
        if (r_fill >= r_len) begin
            w_fill_next = r_len;
        end else begin
            w_fill_next = r_fill + LP_LEN_ONE;
        end
        w_match = w_scan_bit && (w_fill_next == r_len)
                  && (((w_shreg_next ^ r_pattern) & w_mask) == LP_PAT_ZERO);
        w_final = (r_target != LP_CNT_ZERO)
                  && (({1'b0, r_count} + (CNT_W + 1)'(1)) == {1'b0, r_target});
        w_busy_next = (w_state_next == ST_SCAN);
        w_done_next = (w_state_next == ST_DONE);
    end

    // Configuration registers; writes are locked out while scanning.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_pattern <= LP_PAT_ZERO;
            r_len     <= LP_LEN_ZERO;
            r_overlap <= 1'b0;
            r_target  <= LP_CNT_ZERO;
            r_cfg_err <= 1'b1;
        end else if (cfg_we && (r_state != ST_SCAN)) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
            r_cfg_err <= len_illegal(cfg_len);
        end
    end

    // Shift history, fill level and saturating match counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shreg <= LP_PAT_ZERO;
            r_fill  <= LP_LEN_ZERO;
            r_count <= LP_CNT_ZERO;
        end else if (w_start_ok) begin
            r_shreg <= LP_PAT_ZERO;
            r_fill  <= LP_LEN_ZERO;
            r_count <= LP_CNT_ZERO;
        end else if (w_scan_bit) begin
            if (w_match) begin
                r_count <= sat_inc(r_count);
                // Without overlap the next match must be built from fresh bits only.
                if (r_overlap) begin
                    r_shreg <= w_shreg_next;
                    r_fill  <= w_fill_next;
                end else begin
                    r_shreg <= LP_PAT_ZERO;
                    r_fill  <= LP_LEN_ZERO;
                end
            end else begin
                r_shreg <= w_shreg_next;
                r_fill  <= w_fill_next;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;
    assign match       = w_match;
    assign match_count = r_count;

endmodule
